// File: rtl/diff_freq_serial_in.sv
// Serial frame receiver: each bit has its own period (fast or slow) selected by a
// per-bit frequency pattern; the frame is reassembled and reported with a done tick.
//
// state   | meaning
// S_IDLE  | waiting for an accepted start
// S_ALIGN | ALIGN_DLY cycles covering the input synchronizer latency
// S_DATA  | sampling bits mid-period and assembling the frame
module diff_freq_serial_in #(
    parameter int DATA_BIT  = 32,
    parameter int FAST_DIV  = 4,
    parameter int SLOW_DIV  = 8,
    parameter int ALIGN_DLY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_serial_in,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_bit_tick,
    output logic                o_done_tick,
    output logic                o_busy
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int TW      = $clog2(MAX_DIV) + 1;
    localparam int BW      = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int AW      = $clog2(ALIGN_DLY + 1);

    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BIT - 1);
    localparam logic [AW-1:0] LAST_ALIGN = AW'(ALIGN_DLY - 1);
    localparam logic [TW-1:0] FAST_P     = TW'(FAST_DIV);
    localparam logic [TW-1:0] SLOW_P     = TW'(SLOW_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_DATA  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [DATA_BIT-1:0] freq_q, freq_d;
    logic                mode_q, mode_d;
    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [AW-1:0]       align_cnt_q, align_cnt_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic                done_q, done_d;

    logic                serial_s;
    logic [TW-1:0]       period;
    logic                last_tick;
    logic                last_bit;
    logic                sample_now;
    logic                start_ok;
    logic [DATA_BIT-1:0] shift_smp;

    assign serial_s   = sync_q[1];
    assign period     = freq_q[bit_cnt_q] ? FAST_P : SLOW_P;
    assign last_tick  = (tick_cnt_q == period - TW'(1));
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign sample_now = (state_q == S_DATA) && (tick_cnt_q == (period >> 1));
    assign start_ok   = i_start && !i_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            freq_q      <= '0;
            mode_q      <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            align_cnt_q <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            freq_q      <= freq_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            align_cnt_q <= align_cnt_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (i_stop)                           state_d = S_IDLE;
                else if (align_cnt_q == LAST_ALIGN)   state_d = S_DATA;
            end
            S_DATA: begin
                if (i_stop)                                state_d = S_IDLE;
                else if (last_tick && last_bit && !mode_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync_d      = {sync_q[0], i_serial_in};
        freq_d      = freq_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        align_cnt_d = align_cnt_q;
        data_d      = data_q;
        done_d      = 1'b0;

        // With a 2-clock period the sample and the last tick coincide, so the
        // completed word must include the sample taken in this same cycle.
        shift_smp = shift_q;
        if (sample_now) shift_smp[bit_cnt_q] = serial_s;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    freq_d      = i_freq_pattern;
                    mode_d      = i_mode;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    tick_cnt_d  = '0;
                    align_cnt_d = '0;
                end
            end
            S_ALIGN: begin
                align_cnt_d = align_cnt_q + AW'(1);
            end
            S_DATA: begin
                if (!i_stop) begin
                    shift_d = shift_smp;
                    if (last_tick) begin
                        tick_cnt_d = '0;
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            data_d    = shift_smp;
                            done_d    = 1'b1;
                            if (mode_q) shift_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_bit_tick  = (state_q == S_DATA) && last_tick;
        o_data      = data_q;
        o_done_tick = done_q;
    end

endmodule
